// File: rtl/tau_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package tau_fetch_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH_MIN = 2;
  localparam int unsigned FETCH_DEFAULT_AW     = 8;
  localparam int unsigned FETCH_DEFAULT_DW     = 8;

  typedef struct packed {
    logic [FETCH_DEFAULT_AW-1:0] pc;
    logic [FETCH_DEFAULT_DW-1:0] data;
  } fetch_entry_t;

  function automatic bit is_pow2(int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// ROM bus, branch redirect and decode handshake of the fetch stage.
interface instruction_fetch_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic                     rom_read_enable;
  logic [ADDRESS_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0]    rom_data;
  logic                     branch_valid;
  logic [ADDRESS_WIDTH-1:0] branch_target;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [DATA_WIDTH-1:0]    instr_data;
  logic [ADDRESS_WIDTH-1:0] instr_pc;

  modport master (
    output rom_read_enable, rom_address, instr_valid, instr_data, instr_pc,
    input  rom_data, branch_valid, branch_target, instr_ready
  );

  modport slave (
    input  rom_read_enable, rom_address, instr_valid, instr_data, instr_pc,
    output rom_data, branch_valid, branch_target, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and first-word-fall-through head.
module fetch_fifo
  import tau_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH_MIN,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           push_entry,
  output entry_t           head_entry,
  output logic [CNT_W-1:0] count
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  no_overflow_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !flush && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-based ROM read issue, return capture and branch flush.
module instruction_fetch
  import tau_fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic                 clock,
  input logic                 reset_n,
  instruction_fetch_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PEND_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < FETCH_FIFO_DEPTH_MIN)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= %0d", FETCH_FIFO_DEPTH_MIN);
  end

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic                     inflight_q, inflight_d;
  logic [CNT_W-1:0]         fifo_count;
  logic [PEND_W-1:0]        pending;
  logic                     pop, push, issue;
  entry_t                   head, push_entry;

  assign pop = bus.instr_valid && bus.instr_ready;

  // A branch flushes both the FIFO and the returning word, so it frees all credit.
  always_comb begin
    bus.rom_address = bus.branch_valid ? bus.branch_target : pc_q;
    pending = '0;
    if (!bus.branch_valid) begin
      pending = {1'b0, fifo_count} + PEND_W'(inflight_q) - PEND_W'(pop);
    end
    issue      = reset_n && (pending < PEND_W'(FIFO_DEPTH));
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (issue) begin
      pc_d     = bus.rom_address + 1'b1;
      req_pc_d = bus.rom_address;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_VECTOR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign push            = inflight_q && !bus.branch_valid;
  assign push_entry.pc   = req_pc_q;
  assign push_entry.data = bus.rom_data;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (bus.branch_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head),
    .count      (fifo_count)
  );

  assign bus.rom_read_enable = issue;
  assign bus.instr_valid     = (fifo_count != '0);
  assign bus.instr_data      = head.data;
  assign bus.instr_pc        = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-vector and scoreboard bench for instruction_fetch (reset vectors 00 and FE).
module tb_instruction_fetch;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clock = ~clock;

  instruction_fetch_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
  instruction_fetch_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus1 ();

  instruction_fetch #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (2),
    .RESET_VECTOR  (8'h00)
  ) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  instruction_fetch #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (2),
    .RESET_VECTOR  (8'hFE)
  ) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  // ROM contents: word = address + 8'h10, one-cycle read latency.
  always_ff @(posedge clock) begin
    if (bus0.rom_read_enable) bus0.rom_data <= bus0.rom_address + 8'h10;
    if (bus1.rom_read_enable) bus1.rom_data <= bus1.rom_address + 8'h10;
  end

  typedef struct {
    logic       ready;
    logic       branch;
    logic [7:0] target;
    logic       e_valid;
    logic [7:0] e_data;
    logic [7:0] e_pc;
    logic       e_rre;
    logic [7:0] e_addr;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_pc, exp1_pc, held_data, held_pc;
    logic       stall_prev;
    int         pops;

    //           rdy br  tgt    vld data   pc     rre addr
    vecs[0]  = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00};
    vecs[1]  = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h01};
    vecs[2]  = '{1, 0, 8'h00, 1, 8'h10, 8'h00, 1, 8'h02};
    vecs[3]  = '{1, 0, 8'h00, 1, 8'h11, 8'h01, 1, 8'h03};
    vecs[4]  = '{0, 0, 8'h00, 1, 8'h12, 8'h02, 0, 8'h04};
    vecs[5]  = '{0, 0, 8'h00, 1, 8'h12, 8'h02, 0, 8'h04};
    vecs[6]  = '{0, 0, 8'h00, 1, 8'h12, 8'h02, 0, 8'h04};
    vecs[7]  = '{0, 0, 8'h00, 1, 8'h12, 8'h02, 0, 8'h04};
    vecs[8]  = '{0, 0, 8'h00, 1, 8'h12, 8'h02, 0, 8'h04};
    vecs[9]  = '{0, 1, 8'h40, 1, 8'h12, 8'h02, 1, 8'h40};
    vecs[10] = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h41};
    vecs[11] = '{1, 0, 8'h00, 1, 8'h50, 8'h40, 1, 8'h42};
    vecs[12] = '{1, 1, 8'h80, 1, 8'h51, 8'h41, 1, 8'h80};
    vecs[13] = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h81};
    vecs[14] = '{1, 0, 8'h00, 1, 8'h90, 8'h80, 1, 8'h82};
    vecs[15] = '{1, 0, 8'h00, 1, 8'h91, 8'h81, 1, 8'h83};

    bus0.instr_ready   = 1'b0;
    bus0.branch_valid  = 1'b0;
    bus0.branch_target = 8'h00;
    bus1.instr_ready   = 1'b1;
    bus1.branch_valid  = 1'b0;
    bus1.branch_target = 8'h00;

    repeat (3) @(posedge clock);
    #1;
    check("reset rre", 32'(bus0.rom_read_enable), 32'h0);
    check("reset addr", 32'(bus0.rom_address), 32'h00);
    check("reset valid", 32'(bus0.instr_valid), 32'h0);
    check("reset data", 32'(bus0.instr_data), 32'h00);
    check("reset pc", 32'(bus0.instr_pc), 32'h00);
    check("reset addr fe", 32'(bus1.rom_address), 32'hFE);

    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus0.instr_ready   = vecs[i].ready;
      bus0.branch_valid  = vecs[i].branch;
      bus0.branch_target = vecs[i].target;
      #1;
      check($sformatf("c%0d valid", i), 32'(bus0.instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("c%0d rre", i), 32'(bus0.rom_read_enable), 32'(vecs[i].e_rre));
      check($sformatf("c%0d addr", i), 32'(bus0.rom_address), 32'(vecs[i].e_addr));
      if (vecs[i].e_valid) begin
        check($sformatf("c%0d data", i), 32'(bus0.instr_data), 32'(vecs[i].e_data));
        check($sformatf("c%0d pc", i), 32'(bus0.instr_pc), 32'(vecs[i].e_pc));
      end
      if (i >= 2 && i <= 5) begin
        exp1_pc = 8'hFE + 8'(i - 2);
        check($sformatf("wrap c%0d valid", i), 32'(bus1.instr_valid), 32'h1);
        check($sformatf("wrap c%0d pc", i), 32'(bus1.instr_pc), 32'(exp1_pc));
        check($sformatf("wrap c%0d data", i), 32'(bus1.instr_data), 32'(8'(exp1_pc + 8'h10)));
      end
      next_cycle();
    end

    // Mid-stream reset: outputs return to reset values at once.
    bus0.branch_valid = 1'b0;
    bus0.instr_ready  = 1'b1;
    repeat (3) next_cycle();
    reset_n = 1'b0;
    #1;
    check("midrst rre", 32'(bus0.rom_read_enable), 32'h0);
    check("midrst addr", 32'(bus0.rom_address), 32'h00);
    check("midrst valid", 32'(bus0.instr_valid), 32'h0);
    check("midrst data", 32'(bus0.instr_data), 32'h00);
    check("midrst pc", 32'(bus0.instr_pc), 32'h00);
    check("midrst valid fe", 32'(bus1.instr_valid), 32'h0);
    check("midrst addr fe", 32'(bus1.rom_address), 32'hFE);
    next_cycle();
    reset_n = 1'b1;
    #1;
    check("restart rre", 32'(bus0.rom_read_enable), 32'h1);
    check("restart addr", 32'(bus0.rom_address), 32'h00);
    next_cycle();
    check("restart c1 valid", 32'(bus0.instr_valid), 32'h0);
    next_cycle();
    check("restart c2 valid", 32'(bus0.instr_valid), 32'h1);
    check("restart c2 pc", 32'(bus0.instr_pc), 32'h00);
    check("restart c2 data", 32'(bus0.instr_data), 32'h10);
    check("restart c2 pc fe", 32'(bus1.instr_pc), 32'hFE);

    // Random ready on dut0; dut1 drains every cycle and must wrap with no gap.
    exp_pc     = 8'h00;
    exp1_pc    = 8'hFE;
    stall_prev = 1'b0;
    held_data  = 8'h00;
    held_pc    = 8'h00;
    pops       = 0;
    for (int k = 0; k < 1000; k++) begin
      bus0.instr_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        check($sformatf("r%0d hold valid", k), 32'(bus0.instr_valid), 32'h1);
        check($sformatf("r%0d hold pc", k), 32'(bus0.instr_pc), 32'(held_pc));
        check($sformatf("r%0d hold data", k), 32'(bus0.instr_data), 32'(held_data));
      end
      if (bus0.instr_valid && bus0.instr_ready) begin
        check($sformatf("r%0d pc", k), 32'(bus0.instr_pc), 32'(exp_pc));
        check($sformatf("r%0d data", k), 32'(bus0.instr_data), 32'(8'(exp_pc + 8'h10)));
        exp_pc = exp_pc + 8'h01;
        pops++;
      end
      stall_prev = bus0.instr_valid && !bus0.instr_ready;
      held_data  = bus0.instr_data;
      held_pc    = bus0.instr_pc;
      check($sformatf("r%0d fe valid", k), 32'(bus1.instr_valid), 32'h1);
      check($sformatf("r%0d fe pc", k), 32'(bus1.instr_pc), 32'(exp1_pc));
      exp1_pc = exp1_pc + 8'h01;
      next_cycle();
    end
    check("random throughput", 32'(pops >= 300), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
